rco_event_logger: RTL and testbench
===================================

Name: rco_event_logger

Overview:
- Sits directly downstream of the 4-bit up/down/load counter stage.
- Consumes the counter's Q, rco, modo and enable, and captures every fresh rco event as a record {modo, Q} in a small FIFO.
- Presents captured records to the next stage over a valid/ready handshake.
- Keeps a saturating event total and a sticky overflow flag for status readout.

Parameters:
- DEPTH, 8, FIFO entries; power of 2, minimum 2.
- AW, 3, pointer width, equal to log2(DEPTH).
- CNTW, 16, width of the saturating event total.

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-low reset
- cnt_enable  input  1  enable currently driven to the counter stage
- cnt_modo  input  2  mode currently driven to the counter: 00 +1, 01 -1, 10 -3, 11 load
- cnt_q  input  4  counter Q output
- cnt_rco  input  1  counter rco output
- clr  input  1  synchronous clear of ev_total and overflow; FIFO contents untouched
- out_valid  output  1  FIFO non-empty
- out_ready  input  1  downstream accepts the head record
- out_data  output  6  head record {modo[1:0], q[3:0]}
- fill  output  AW+1  number of stored records, 0..DEPTH
- ev_total  output  CNTW  fresh rco events seen, saturating
- overflow  output  1  sticky; set when an event is dropped because the FIFO is full

Behaviour:
- Reset: reset==0 at a rising edge forces the following outputs and state.
  - out_valid=0, out_data=0, fill=0, ev_total=0, overflow=0.
  - Pointers = 0; en_d=0; modo_d=0.
  - Memory contents are don't-care.
  - Reset has priority over clr, push and pop.
  - Reset mid-stream discards all stored records.
- Freshness: the counter updates Q/rco only on edges where its enable was 1, and holds them when enable is 0.
  - Register en_d <= cnt_enable and modo_d <= cnt_modo every cycle.
  - An event is fresh at edge k when en_d==1 and cnt_rco==1, i.e. the counter was enabled at edge k-1 and raised rco there.
  - A held rco with en_d==0 is never counted, so one event is never counted twice.
- Record: {modo_d, cnt_q}, i.e. the mode in force at the edge that produced the event, plus the resulting Q.
- Load mode holds rco=1 on every enabled edge. Each such cycle is a separate event; this behaviour is required.
- Push: push_req = fresh event.
  - Accepted if fill<DEPTH, or if a pop occurs in the same cycle (full with simultaneous pop: both happen, fill unchanged).
  - Otherwise the record is dropped and overflow <= 1.
- Pop: pop = out_valid & out_ready; rd_ptr advances.
- Push and pop in the same cycle: fill unchanged.
- Empty FIFO plus push: the record becomes visible on out_valid/out_data after the capturing edge. There is no same-cycle fall-through to the input.
- Latency:
  - counter event at edge k-1
  - captured at edge k
  - out_valid=1 from edge k
  - earliest pop at edge k+1
- out_data:
  - equals mem[rd_ptr] whenever out_valid=1
  - holds stable while out_valid=1 and out_ready=0
  - out_data is 0 when empty
- Pointers: AW bits, wrap from DEPTH-1 to 0. fill is tracked explicitly; full = (fill==DEPTH), empty = (fill==0).
- ev_total:
  - increments on every fresh event, including dropped ones
  - saturates at 2^CNTW-1
  - clr=1 zeroes it; clr wins over an increment in the same cycle
- overflow: set on a drop; cleared only by clr or reset. If a drop and clr occur in the same cycle, clr wins (overflow=0).
- No combinational path from out_ready to out_valid or out_data.

Test Plan:
- Reset then enable=1, modo=00, counter runs from Q=1110 -> Q=1111 then Q=0000, rco=1 one cycle -> exactly one record 0x00 captured; out_valid=1 one edge after rco rises; ev_total=1.
- Event captured, then enable dropped for 5 cycles with rco held at 1 -> no further records; fill stays 1; ev_total stays 1.
- modo=11, D=0101, enable=1 for 3 edges, out_ready=0 -> three records 0x35; fill=3; out_data stable at 0x35.
- out_ready=0, modo=01 with Q wrapping 9 times (DEPTH=8) -> fill=8, overflow=1, ev_total=9; then out_ready=1 drains 8 records in order; overflow stays 1 until clr.
- FIFO full, fresh event and out_ready=1 in the same cycle -> pop and push both happen, fill=8, overflow=0; then reset=0 mid-drain -> fill=0, out_valid=0, ev_total=0 on the next edge.
- ev_total preloaded near saturation (CNTW=4 build, 16 events) -> ev_total holds at 15; clr asserted together with an event -> ev_total=0.

Source files
------------

// File: rtl/rco_event_logger.sv
// Captures fresh rco events from the upstream 4-bit counter as {modo, Q} records
// in a small FIFO, with a saturating event total and a sticky overflow flag.
module rco_event_logger #(
   parameter int DEPTH = 8,
   parameter int AW    = 3,
   parameter int CNTW  = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            cnt_enable,
   input  logic [1:0]      cnt_modo,
   input  logic [3:0]      cnt_q,
   input  logic            cnt_rco,
   input  logic            clr,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [5:0]      out_data,
   output logic [AW:0]     fill,
   output logic [CNTW-1:0] ev_total,
   output logic            overflow
);

   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   logic            en_q;
   logic [1:0]      modo_q;
   logic [5:0]      mem [DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [AW:0]     fill_q, fill_d;
   logic [CNTW-1:0] total_q;
   logic            overflow_q;

   logic fresh, empty, full, pop, push, drop;

   // rco only counts when the counter was actually enabled on the edge that raised it
   assign fresh = en_q & cnt_rco;
   assign empty = (fill_q == '0);
   assign full  = (fill_q == FULL_LVL);
   assign pop   = ~empty & out_ready;
   assign push  = fresh & (~full | pop);
   assign drop  = fresh & ~push;

   always_comb begin
      fill_d = fill_q;
      if (push && !pop) begin
         fill_d = fill_q + (AW+1)'(1);
      end else if (pop && !push) begin
         fill_d = fill_q - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         en_q       <= 1'b0;
         modo_q     <= 2'b00;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fill_q     <= '0;
         total_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         en_q   <= cnt_enable;
         modo_q <= cnt_modo;
         fill_q <= fill_d;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         if (clr) begin
            total_q    <= '0;
            overflow_q <= 1'b0;
         end else begin
            if (fresh && (total_q != '1)) begin
               total_q <= total_q + CNTW'(1);
            end
            if (drop) begin
               overflow_q <= 1'b1;
            end
         end
      end
   end

   // Storage has no reset; fill and pointers define which entries are meaningful
   always_ff @(posedge clk) begin
      if (reset && push) begin
         mem[wr_ptr_q] <= {modo_q, cnt_q};
      end
   end

   assign out_valid = ~empty;
   assign out_data  = empty ? 6'd0 : mem[rd_ptr_q];
   assign fill      = fill_q;
   assign ev_total  = total_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_rco_event_logger.sv
// Randomized and directed bench for rco_event_logger against a queue-based reference
// model; a second instance with a 4-bit event total checks saturation.
module tb_rco_event_logger;

   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cnt_enable = 1'b0;
   logic [1:0]  cnt_modo = 2'b00;
   logic [3:0]  cnt_q = 4'h0;
   logic        cnt_rco = 1'b0;
   logic        clr = 1'b0;
   logic        out_ready = 1'b0;
   logic [3:0]  ld = 4'h0;

   logic        out_valid, out_valid_4;
   logic [5:0]  out_data, out_data_4;
   logic [AW:0] fill, fill_4;
   logic [15:0] ev_total;
   logic [3:0]  ev_total_4;
   logic        overflow, overflow_4;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   logic [5:0] mq[$];
   int         m_t16 = 0;
   int         m_t4  = 0;
   logic       m_ovf = 1'b0;
   logic       m_en  = 1'b0;
   logic [1:0] m_modo = 2'b00;

   always #5 clk = ~clk;

   rco_event_logger #(.DEPTH(DEPTH), .AW(AW), .CNTW(16)) u_dut (
      .clk(clk), .reset(reset), .cnt_enable(cnt_enable), .cnt_modo(cnt_modo),
      .cnt_q(cnt_q), .cnt_rco(cnt_rco), .clr(clr), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .fill(fill),
      .ev_total(ev_total), .overflow(overflow)
   );

   rco_event_logger #(.DEPTH(DEPTH), .AW(AW), .CNTW(4)) u_dut4 (
      .clk(clk), .reset(reset), .cnt_enable(cnt_enable), .cnt_modo(cnt_modo),
      .cnt_q(cnt_q), .cnt_rco(cnt_rco), .clr(clr), .out_valid(out_valid_4),
      .out_ready(out_ready), .out_data(out_data_4), .fill(fill_4),
      .ev_total(ev_total_4), .overflow(overflow_4)
   );

   function automatic logic exp_valid();
      return mq.size() != 0;
   endfunction

   function automatic logic [5:0] exp_data();
      return (mq.size() != 0) ? mq[0] : 6'd0;
   endfunction

   function automatic logic [AW:0] exp_fill();
      return (AW+1)'(mq.size());
   endfunction

   // One clock edge: advances the reference model and the upstream counter model
   // using the input values presented just before the edge.
   task automatic tick();
      logic       p_en, p_rco, p_ready, p_clr, p_reset, fresh, drop;
      logic [1:0] p_modo;
      logic [3:0] p_q, p_ld;
      p_en = cnt_enable; p_modo = cnt_modo; p_q = cnt_q; p_rco = cnt_rco;
      p_ready = out_ready; p_clr = clr; p_reset = reset; p_ld = ld;
      @(posedge clk);
      #1;
      if (!p_reset) begin
         mq.delete();
         m_t16 = 0; m_t4 = 0; m_ovf = 1'b0; m_en = 1'b0; m_modo = 2'b00;
      end else begin
         fresh = m_en && p_rco;
         drop  = 1'b0;
         if (mq.size() != 0 && p_ready) mq.delete(0);
         if (fresh) begin
            if (mq.size() < DEPTH) mq.push_back({m_modo, p_q});
            else drop = 1'b1;
         end
         if (p_clr) begin
            m_t16 = 0; m_t4 = 0; m_ovf = 1'b0;
         end else begin
            if (fresh) begin
               if (m_t16 < 65535) m_t16++;
               if (m_t4 < 15) m_t4++;
            end
            if (drop) m_ovf = 1'b1;
         end
         m_en = p_en; m_modo = p_modo;
      end
      if (p_en) begin
         case (p_modo)
            2'b00: begin cnt_rco = (p_q == 4'hF); cnt_q = p_q + 4'd1; end
            2'b01: begin cnt_rco = (p_q == 4'h0); cnt_q = p_q - 4'd1; end
            2'b10: begin cnt_rco = (p_q < 4'd3);  cnt_q = p_q - 4'd3; end
            default: begin cnt_rco = 1'b1; cnt_q = p_ld; end
         endcase
      end
   endtask

   task automatic do_reset();
      reset = 1'b0; cnt_enable = 1'b0; clr = 1'b0; out_ready = 1'b0;
      tick();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0; cnt_enable = 1'b0; clr = 1'b0; out_ready = 1'b0;
      tick(); tick();
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", out_valid); end
      n_tests++; if (out_data !== 6'd0) begin n_fail++; $display("FAIL reset_data: got %0h expected 0", out_data); end
      n_tests++; if (fill !== '0) begin n_fail++; $display("FAIL reset_fill: got %0d expected 0", fill); end
      n_tests++; if (ev_total !== 16'd0) begin n_fail++; $display("FAIL reset_total: got %0d expected 0", ev_total); end
      n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %0b expected 0", overflow); end
      n_tests++; if (ev_total_4 !== 4'd0) begin n_fail++; $display("FAIL reset_total4: got %0d expected 0", ev_total_4); end
      reset = 1'b1;
      $display("[TB] test_reset done");
   endtask

   task automatic test_single_event();
      do_reset();
      cnt_modo = 2'b00; cnt_q = 4'hE; cnt_rco = 1'b0;
      cnt_enable = 1'b1;
      tick();                 // Q -> F
      tick();                 // Q -> 0, rco = 1
      cnt_enable = 1'b0;      // counter now holds rco = 1
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %0b expected 0", out_valid); end
      tick();
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %0b expected 1", out_valid); end
      n_tests++; if (out_data !== 6'h00) begin n_fail++; $display("FAIL single_data: got %0h expected 00", out_data); end
      n_tests++; if (ev_total !== 16'd1) begin n_fail++; $display("FAIL single_total: got %0d expected 1", ev_total); end
      for (int i = 0; i < 5; i++) begin
         tick();
         n_tests++; if (fill !== 4'd1 || fill !== exp_fill()) begin n_fail++; $display("FAIL held_rco_fill: got %0d expected 1", fill); end
         n_tests++; if (ev_total !== 16'd1) begin n_fail++; $display("FAIL held_rco_total: got %0d expected 1", ev_total); end
      end
      $display("[TB] test_single_event done fill=%0d total=%0d", fill, ev_total);
   endtask

   task automatic test_load();
      do_reset();
      cnt_modo = 2'b11; ld = 4'h5; out_ready = 1'b0; cnt_enable = 1'b1;
      repeat (3) tick();
      cnt_enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_tests++; if (out_data !== 6'h35) begin n_fail++; $display("FAIL load_data: got %0h expected 35", out_data); end
         n_tests++; if (fill !== exp_fill()) begin n_fail++; $display("FAIL load_fill_model: got %0d expected %0d", fill, exp_fill()); end
      end
      n_tests++; if (fill !== 4'd3) begin n_fail++; $display("FAIL load_fill: got %0d expected 3", fill); end
      $display("[TB] test_load done fill=%0d data=%0h", fill, out_data);
   endtask

   task automatic test_overflow();
      do_reset();
      cnt_modo = 2'b01; cnt_q = 4'h0; cnt_rco = 1'b0; out_ready = 1'b0;
      cnt_enable = 1'b1;
      repeat (129) tick();
      cnt_enable = 1'b0;
      repeat (3) tick();
      n_tests++; if (fill !== 4'd8) begin n_fail++; $display("FAIL ovf_fill: got %0d expected 8", fill); end
      n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %0b expected 1", overflow); end
      n_tests++; if (ev_total !== 16'd9) begin n_fail++; $display("FAIL ovf_total: got %0d expected 9", ev_total); end
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         n_tests++; if (out_data !== exp_data()) begin n_fail++; $display("FAIL drain_data[%0d]: got %0h expected %0h", i, out_data, exp_data()); end
         tick();
      end
      n_tests++; if (fill !== 4'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got fill %0d valid %0b expected 0/0", fill, out_valid); end
      n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %0b expected 1", overflow); end
      out_ready = 1'b0; clr = 1'b1;
      tick();
      clr = 1'b0;
      n_tests++; if (overflow !== 1'b0 || ev_total !== 16'd0) begin n_fail++; $display("FAIL ovf_clr: got ovf %0b total %0d expected 0/0", overflow, ev_total); end
      $display("[TB] test_overflow done");
   endtask

   task automatic test_back_to_back();
      do_reset();
      cnt_modo = 2'b11; out_ready = 1'b0; cnt_enable = 1'b1;
      for (int i = 0; i < 9; i++) begin
         ld = 4'(i + 1);
         tick();
      end
      n_tests++; if (fill !== 4'd8 || overflow !== 1'b0) begin n_fail++; $display("FAIL b2b_full: got fill %0d ovf %0b expected 8/0", fill, overflow); end
      ld = 4'h9; out_ready = 1'b1;
      tick();
      n_tests++; if (fill !== 4'd8) begin n_fail++; $display("FAIL b2b_fill: got %0d expected 8", fill); end
      n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL b2b_ovf: got %0b expected 0", overflow); end
      n_tests++; if (out_data !== exp_data()) begin n_fail++; $display("FAIL b2b_head: got %0h expected %0h", out_data, exp_data()); end
      cnt_enable = 1'b0;
      tick(); tick();
      n_tests++; if (fill !== exp_fill()) begin n_fail++; $display("FAIL b2b_drain_fill: got %0d expected %0d", fill, exp_fill()); end
      reset = 1'b0;
      tick();
      reset = 1'b1;
      n_tests++; if (fill !== 4'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_fifo: got fill %0d valid %0b expected 0/0", fill, out_valid); end
      n_tests++; if (ev_total !== 16'd0 || out_data !== 6'd0) begin n_fail++; $display("FAIL midreset_total: got total %0d data %0h expected 0/0", ev_total, out_data); end
      $display("[TB] test_back_to_back done");
   endtask

   task automatic test_saturate();
      do_reset();
      cnt_modo = 2'b11; ld = 4'hA; out_ready = 1'b1; cnt_enable = 1'b1;
      repeat (20) tick();
      n_tests++; if (ev_total_4 !== 4'd15) begin n_fail++; $display("FAIL sat_total4: got %0d expected 15", ev_total_4); end
      n_tests++; if (ev_total !== 16'd19) begin n_fail++; $display("FAIL sat_total16: got %0d expected 19", ev_total); end
      clr = 1'b1;
      tick();
      clr = 1'b0;
      n_tests++; if (ev_total_4 !== 4'd0 || ev_total !== 16'd0) begin n_fail++; $display("FAIL clr_wins: got %0d/%0d expected 0/0", ev_total_4, ev_total); end
      cnt_enable = 1'b0;
      tick();
      $display("[TB] test_saturate done");
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 600; i++) begin
         cnt_enable = ($urandom_range(0, 3) != 0);
         cnt_modo   = 2'($urandom_range(0, 3));
         ld         = 4'($urandom_range(0, 15));
         out_ready  = (i < 300) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 1) == 1);
         clr        = ($urandom_range(0, 63) == 0);
         tick();
         n_tests++; if (out_valid !== exp_valid()) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %0b expected %0b", i, out_valid, exp_valid()); end
         n_tests++; if (out_data !== exp_data()) begin n_fail++; $display("FAIL rnd_data[%0d]: got %0h expected %0h", i, out_data, exp_data()); end
         n_tests++; if (fill !== exp_fill()) begin n_fail++; $display("FAIL rnd_fill[%0d]: got %0d expected %0d", i, fill, exp_fill()); end
         n_tests++; if (ev_total !== 16'(m_t16)) begin n_fail++; $display("FAIL rnd_total[%0d]: got %0d expected %0d", i, ev_total, m_t16); end
         n_tests++; if (ev_total_4 !== 4'(m_t4)) begin n_fail++; $display("FAIL rnd_total4[%0d]: got %0d expected %0d", i, ev_total_4, m_t4); end
         n_tests++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf[%0d]: got %0b expected %0b", i, overflow, m_ovf); end
      end
      clr = 1'b0;
      $display("[TB] test_random done fill=%0d total=%0d", fill, ev_total);
   endtask

   initial begin
      test_reset();
      test_single_event();
      test_load();
      test_overflow();
      test_back_to_back();
      test_saturate();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
